// File: rtl/image_xform_engine.sv
// Per-pixel geometric transform engine: fetches each destination pixel's source word,
// or substitutes a fill value, and writes it out in raster order into ping-pong buffers.
module image_xform_engine #(
    parameter int                DATA_W    = 64,
    parameter int                ADDR_W    = 32,
    parameter int                H_ACT     = 1024,
    parameter int                V_ACT     = 768,
    parameter int                RD_BASE0  = 2073600,
    parameter int                RD_BASE1  = 0,
    parameter int                WR_BASE0  = 6220800,
    parameter int                WR_BASE1  = 4147200,
    parameter logic [DATA_W-1:0] FILL_WORD = '0,
    parameter int                TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    input  logic [2:0]        cfg_mode,
    input  logic [11:0]       cfg_shift_x,
    input  logic [11:0]       cfg_shift_y,
    input  logic [3:0]        cfg_scale,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [9:0]        rd_burst_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rd_burst_finish,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [9:0]        wr_burst_len,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_burst_finish,
    output logic              buf_sel,
    output logic              frame_done,
    output logic              busy,
    output logic              error
);
    localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, CALC, READ, WRITE, NEXT} state_t;
    state_t state, state_n;

    logic [2:0]        sh_mode, act_mode;
    logic [11:0]       sh_shift_x, sh_shift_y, act_shift_x, act_shift_y;
    logic [3:0]        sh_scale, act_scale;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [WW-1:0]     wdog;
    logic signed [13:0] xs, ys, sx, sy;
    logic [13:0]       scale_eff;
    logic              in_range, last_x, last_y, wd_hit;
    logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
    logic              unused_ok;

    assign rd_burst_len = 10'd1;
    assign wr_burst_len = 10'd1;
    assign unused_ok    = &{1'b0, wr_ready};

    // Destination -> source coordinate map, evaluated during CALC
    always_comb begin
        xs        = 14'(x);
        ys        = 14'(y);
        scale_eff = (act_scale == 4'd0) ? 14'd1 : 14'(act_scale);
        sx        = xs;
        sy        = ys;
        case (act_mode)
            3'd1: begin
                sx = xs - {{2{act_shift_x[11]}}, act_shift_x};
                sy = ys - {{2{act_shift_y[11]}}, act_shift_y};
            end
            3'd2: begin
                sx = $signed(14'(x) * scale_eff);
                sy = $signed(14'(y) * scale_eff);
            end
            3'd3: sx = 14'(H_ACT - 1) - xs;
            3'd4: sy = 14'(V_ACT - 1) - ys;
            3'd5: begin
                sx = 14'(H_ACT - 1) - xs;
                sy = 14'(V_ACT - 1) - ys;
            end
            default: ;
        endcase
    end

    assign in_range  = !sx[13] && (sx < 14'(H_ACT)) && !sy[13] && (sy < 14'(V_ACT));
    assign rd_addr_c = (buf_sel ? ADDR_W'(RD_BASE1) : ADDR_W'(RD_BASE0))
                     + ADDR_W'(sy[12:0]) * ADDR_W'(H_ACT) + ADDR_W'(sx[12:0]);
    assign wr_addr_c = (buf_sel ? ADDR_W'(WR_BASE1) : ADDR_W'(WR_BASE0))
                     + ADDR_W'(y) * ADDR_W'(H_ACT) + ADDR_W'(x);
    assign last_x    = (x == XW'(H_ACT - 1));
    assign last_y    = (y == YW'(V_ACT - 1));
    assign wd_hit    = (wdog == WW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (enable) state_n = CALC;
            CALC:  state_n = in_range ? READ : WRITE;
            READ:  if (rd_burst_finish) state_n = WRITE;
                   else if (wd_hit)     state_n = IDLE;
            WRITE: if (wr_burst_finish) state_n = NEXT;
                   else if (wd_hit)     state_n = IDLE;
            NEXT:  state_n = (last_x && last_y) ? IDLE : CALC;
            default: state_n = IDLE;
        endcase
    end

    // Watchdog restarts on every state change, so each handshake gets a full budget
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                 wdog <= '0;
        else if (state_n != state)               wdog <= '0;
        else if (state == READ || state == WRITE) wdog <= wdog + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_mode    <= 3'd0;
            sh_shift_x <= '0;
            sh_shift_y <= '0;
            sh_scale   <= 4'd1;
        end else if (cfg_valid) begin
            sh_mode    <= cfg_mode;
            sh_shift_x <= cfg_shift_x;
            sh_shift_y <= cfg_shift_y;
            sh_scale   <= cfg_scale;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_mode    <= 3'd0;
            act_shift_x <= '0;
            act_shift_y <= '0;
            act_scale   <= 4'd1;
            x           <= '0;
            y           <= '0;
            rd_valid    <= 1'b0;
            rd_addr     <= '0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            buf_sel     <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (enable) begin
                    act_mode    <= sh_mode;
                    act_shift_x <= sh_shift_x;
                    act_shift_y <= sh_shift_y;
                    act_scale   <= sh_scale;
                    x           <= '0;
                    y           <= '0;
                    busy        <= 1'b1;
                end
                CALC: if (in_range) begin
                    rd_addr  <= rd_addr_c;
                    rd_valid <= 1'b1;
                end else begin
                    wr_data  <= FILL_WORD;
                    wr_addr  <= wr_addr_c;
                    wr_valid <= 1'b1;
                end
                READ: begin
                    if (rd_ready) wr_data <= rd_data;
                    if (rd_burst_finish) begin
                        rd_valid <= 1'b0;
                        wr_addr  <= wr_addr_c;
                        wr_valid <= 1'b1;
                    end else if (wd_hit) begin
                        rd_valid <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_burst_finish) begin
                        wr_valid <= 1'b0;
                    end else if (wd_hit) begin
                        wr_valid <= 1'b0;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_x) begin
                        x <= x + 1'b1;
                    end else begin
                        x <= '0;
                        if (last_y) begin
                            y          <= '0;
                            frame_done <= 1'b1;
                            buf_sel    <= ~buf_sel;
                            busy       <= 1'b0;
                        end else begin
                            y <= y + 1'b1;
                        end
                    end
                end
                default: begin
                    rd_valid <= 1'b0;
                    wr_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_image_xform_engine.sv
// Directed bench for image_xform_engine on an 8x4 frame with a memory that finishes
// every burst in one cycle unless the read side is deliberately stalled.
module tb_image_xform_engine;
    localparam int RB0 = 2073600;
    localparam int WB0 = 6220800;
    localparam int WB1 = 4147200;

    logic        clk, rst, enable, cfg_valid;
    logic [2:0]  cfg_mode;
    logic [11:0] cfg_shift_x, cfg_shift_y;
    logic [3:0]  cfg_scale;
    logic        rd_valid, rd_ready, rd_burst_finish;
    logic [9:0]  rd_burst_len, wr_burst_len;
    logic [31:0] rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;
    logic        wr_valid, wr_ready, wr_burst_finish;
    logic        buf_sel, frame_done, busy, error;
    logic        rd_hold;

    image_xform_engine #(.H_ACT(8), .V_ACT(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_valid(cfg_valid),
        .cfg_mode(cfg_mode), .cfg_shift_x(cfg_shift_x), .cfg_shift_y(cfg_shift_y),
        .cfg_scale(cfg_scale), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_burst_len(rd_burst_len), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_burst_finish(rd_burst_finish), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_burst_len(wr_burst_len), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_burst_finish(wr_burst_finish), .buf_sel(buf_sel), .frame_done(frame_done),
        .busy(busy), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_ready        = rd_valid & ~rd_hold;
    assign rd_burst_finish = rd_valid & ~rd_hold;
    assign rd_data         = {32'hCAFEF00D, rd_addr};
    assign wr_ready        = wr_valid;
    assign wr_burst_finish = wr_valid;

    // Transaction log: one entry per completed write, tagged with the read (if any) before it
    int          nwr = 0;
    int          nfd = 0;
    logic        pend_rd = 1'b0;
    logic [31:0] pend_ra = '0;
    logic        px_rd [0:1023];
    logic [31:0] px_ra [0:1023];
    logic [31:0] px_wa [0:1023];
    logic [63:0] px_wd [0:1023];

    always @(negedge clk) begin
        if (rst) begin
            pend_rd <= 1'b0;
        end else begin
            if (rd_valid && rd_burst_finish) begin
                pend_rd <= 1'b1;
                pend_ra <= rd_addr;
            end
            if (wr_valid && wr_burst_finish && nwr < 1024) begin
                px_rd[nwr] <= pend_rd;
                px_ra[nwr] <= pend_ra;
                px_wa[nwr] <= wr_addr;
                px_wd[nwr] <= wr_data;
                nwr        <= nwr + 1;
                pend_rd    <= 1'b0;
            end
            if (frame_done) nfd <= nfd + 1;
        end
    end

    int nchk = 0;
    int nbad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_hold = 1'b0;
        enable = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [2:0] m, input logic [11:0] shx, input logic [11:0] shy,
                           input logic [3:0] sc);
        cfg_mode = m; cfg_shift_x = shx; cfg_shift_y = shy; cfg_scale = sc;
        cfg_valid = 1'b1;
        @(posedge clk); #1 cfg_valid = 1'b0;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        @(posedge clk); #1 enable = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!frame_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (!frame_done) chk("frame_done_timeout", 64'(frame_done), 64'd1);
    endtask

    typedef struct {
        logic [2:0]  mode;
        logic [11:0] shx;
        logic [11:0] shy;
        logic [3:0]  scale;
        int          px;
        int          py;
        logic        exp_rd;
        logic [31:0] exp_ra;
    } vec_t;

    vec_t vt [17];

    initial begin
        int cyc, base, fd0, k;
        logic [63:0] exp_wd;

        vt[0]  = '{3'd1, 12'd2,     12'd0,     4'd1, 0, 0, 1'b0, 32'd0};
        vt[1]  = '{3'd1, 12'd2,     12'd0,     4'd1, 1, 0, 1'b0, 32'd0};
        vt[2]  = '{3'd1, 12'd2,     12'd0,     4'd1, 2, 0, 1'b1, 32'(RB0 + 0)};
        vt[3]  = '{3'd1, 12'd2,     12'd0,     4'd1, 7, 3, 1'b1, 32'(RB0 + 29)};
        vt[4]  = '{3'd5, 12'd0,     12'd0,     4'd1, 0, 0, 1'b1, 32'(RB0 + 31)};
        vt[5]  = '{3'd5, 12'd0,     12'd0,     4'd1, 7, 3, 1'b1, 32'(RB0 + 0)};
        vt[6]  = '{3'd3, 12'd0,     12'd0,     4'd1, 1, 2, 1'b1, 32'(RB0 + 22)};
        vt[7]  = '{3'd4, 12'd0,     12'd0,     4'd1, 1, 2, 1'b1, 32'(RB0 + 9)};
        vt[8]  = '{3'd2, 12'd0,     12'd0,     4'd2, 1, 1, 1'b1, 32'(RB0 + 18)};
        vt[9]  = '{3'd2, 12'd0,     12'd0,     4'd2, 4, 0, 1'b0, 32'd0};
        vt[10] = '{3'd2, 12'd0,     12'd0,     4'd2, 3, 1, 1'b1, 32'(RB0 + 22)};
        vt[11] = '{3'd2, 12'd0,     12'd0,     4'd0, 5, 2, 1'b1, 32'(RB0 + 21)};
        vt[12] = '{3'd2, 12'd0,     12'd0,     4'd3, 2, 1, 1'b1, 32'(RB0 + 30)};
        vt[13] = '{3'd1, 12'd0,     12'hFFF,   4'd1, 3, 3, 1'b0, 32'd0};
        vt[14] = '{3'd1, 12'd0,     12'hFFF,   4'd1, 3, 0, 1'b1, 32'(RB0 + 11)};
        vt[15] = '{3'd1, 12'hFFD,   12'd0,     4'd1, 5, 0, 1'b0, 32'd0};
        vt[16] = '{3'd7, 12'd0,     12'd0,     4'd1, 6, 3, 1'b1, 32'(RB0 + 30)};

        rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; rd_hold = 1'b0;
        cfg_mode = '0; cfg_shift_x = '0; cfg_shift_y = '0; cfg_scale = '0;
        #12;
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", wr_data, 64'd0);
        chk("rst_buf_sel", 64'(buf_sel), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rd_burst_len", 64'(rd_burst_len), 64'd1);
        chk("wr_burst_len", 64'(wr_burst_len), 64'd1);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("idle_no_enable_busy", 64'(busy), 64'd0);

        // Full bypass frame on buffer 0
        base = nwr; fd0 = nfd;
        start_frame();
        chk("busy_after_start", 64'(busy), 64'd1);
        wait_done(cyc);
        chk("bypass_latency", 64'(cyc), 64'd129);
        @(posedge clk); #1;
        chk("bypass_frame_done_cnt", 64'(nfd - fd0), 64'd1);
        chk("frame_done_one_cycle", 64'(frame_done), 64'd0);
        chk("bypass_buf_sel", 64'(buf_sel), 64'd1);
        chk("bypass_busy_end", 64'(busy), 64'd0);
        chk("bypass_nwr", 64'(nwr - base), 64'd32);
        for (int p = 0; p < 32; p++) begin
            chk($sformatf("byp%0d_rd", p), 64'(px_rd[base + p]), 64'd1);
            chk($sformatf("byp%0d_ra", p), 64'(px_ra[base + p]), 64'(RB0 + p));
            chk($sformatf("byp%0d_wa", p), 64'(px_wa[base + p]), 64'(WB0 + p));
            chk($sformatf("byp%0d_wd", p), px_wd[base + p], {32'hCAFEF00D, 32'(RB0 + p)});
        end

        // Second bypass frame uses buffer 1
        base = nwr;
        start_frame();
        wait_done(cyc);
        @(posedge clk); #1;
        chk("buf1_px0_ra", 64'(px_ra[base]), 64'd0);
        chk("buf1_px0_wa", 64'(px_wa[base]), 64'(WB1));
        chk("buf1_px31_ra", 64'(px_ra[base + 31]), 64'd31);
        chk("buf1_px31_wa", 64'(px_wa[base + 31]), 64'(WB1 + 31));
        chk("buf1_buf_sel", 64'(buf_sel), 64'd0);

        // Table of single-pixel spot checks, each from a fresh reset on buffer 0
        for (int i = 0; i < 17; i++) begin
            do_reset();
            set_cfg(vt[i].mode, vt[i].shx, vt[i].shy, vt[i].scale);
            base = nwr; fd0 = nfd;
            start_frame();
            wait_done(cyc);
            @(posedge clk); #1;
            k = base + vt[i].py * 8 + vt[i].px;
            exp_wd = vt[i].exp_rd ? {32'hCAFEF00D, vt[i].exp_ra} : 64'd0;
            chk($sformatf("v%0d_frames", i), 64'(nfd - fd0), 64'd1);
            chk($sformatf("v%0d_read", i), 64'(px_rd[k]), 64'(vt[i].exp_rd));
            if (vt[i].exp_rd) chk($sformatf("v%0d_ra", i), 64'(px_ra[k]), 64'(vt[i].exp_ra));
            chk($sformatf("v%0d_wa", i), 64'(px_wa[k]), 64'(WB0 + vt[i].py * 8 + vt[i].px));
            chk($sformatf("v%0d_wd", i), px_wd[k], exp_wd);
        end

        // Watchdog: stalled read trips after 15 READ cycles
        do_reset();
        rd_hold = 1'b1;
        fd0 = nfd;
        start_frame();
        cyc = 0;
        while (!error && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("wd_cycles", 64'(cyc), 64'd17);
        chk("wd_error", 64'(error), 64'd1);
        chk("wd_rd_valid", 64'(rd_valid), 64'd0);
        chk("wd_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        chk("wd_no_frame_done", 64'(nfd - fd0), 64'd0);
        chk("wd_buf_sel", 64'(buf_sel), 64'd0);
        rd_hold = 1'b0;
        base = nwr;
        start_frame();
        wait_done(cyc);
        @(posedge clk); #1;
        chk("wd_error_sticky", 64'(error), 64'd1);
        chk("wd_restart_ra", 64'(px_ra[base]), 64'(RB0));
        chk("wd_restart_wa", 64'(px_wa[base]), 64'(WB0));
        do_reset();
        chk("error_cleared_by_rst", 64'(error), 64'd0);

        // Config written mid-frame or in the start cycle only affects later frames
        base = nwr;
        start_frame();
        repeat (40) @(posedge clk);
        #1 set_cfg(3'd3, 12'd0, 12'd0, 4'd1);
        wait_done(cyc);
        @(posedge clk); #1;
        chk("midcfg_px0_ra", 64'(px_ra[base]), 64'(RB0));
        chk("midcfg_px31_ra", 64'(px_ra[base + 31]), 64'(RB0 + 31));
        base = nwr;
        cfg_mode = 3'd4; cfg_valid = 1'b1; enable = 1'b1;
        @(posedge clk); #1 cfg_valid = 1'b0; enable = 1'b0;
        wait_done(cyc);
        @(posedge clk); #1;
        chk("mirh_buf1_ra", 64'(px_ra[base]), 64'd7);
        chk("mirh_buf1_wa", 64'(px_wa[base]), 64'(WB1));
        base = nwr;
        start_frame();
        wait_done(cyc);
        @(posedge clk); #1;
        chk("mirv_buf0_ra", 64'(px_ra[base]), 64'(RB0 + 24));
        chk("mirv_buf0_wa", 64'(px_wa[base]), 64'(WB0));

        // Reset in the middle of a stalled read drops the request at once
        rd_hold = 1'b1;
        start_frame();
        repeat (3) @(posedge clk);
        #2 chk("pre_rst_rd_valid", 64'(rd_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1 rst = 1'b0; rd_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("post_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nbad);
        $finish;
    end
endmodule
